// File: rtl/fetch_ctrl_pkg.sv
// Shared FSM encoding and constants for the fetch sequencer.
package fetch_ctrl_pkg;

    typedef enum logic [1:0] {
        StBoot  = 2'd0,
        StRun   = 2'd1,
        StFault = 2'd2
    } fetch_state_e;

    localparam logic [31:0] FETCH_RESET_PC = 32'h0000_0000;
    localparam int unsigned PC_INCR        = 4;

endpackage

// File: rtl/fetch_ctrl_if.sv
// Redirect, instruction-memory and decode-side signals of the fetch sequencer.
// master is the sequencer side, slave is the surrounding pipeline/memory side.
interface fetch_ctrl_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  redirect_taken;
    logic [ADDR_WIDTH-1:0] redirect_addr;
    logic                  mem_req;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_gnt;
    logic                  mem_rvalid;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  out_valid;
    logic                  out_ready;
    logic [ADDR_WIDTH-1:0] out_pc;
    logic [DATA_WIDTH-1:0] out_instr;
    logic [ADDR_WIDTH-1:0] out_pc_plus4;
    logic                  fetch_fault;

    modport master (
        input  redirect_taken, redirect_addr, mem_gnt, mem_rvalid, mem_rdata, out_ready,
        output mem_req, mem_addr, out_valid, out_pc, out_instr, out_pc_plus4, fetch_fault
    );

    modport slave (
        output redirect_taken, redirect_addr, mem_gnt, mem_rvalid, mem_rdata, out_ready,
        input  mem_req, mem_addr, out_valid, out_pc, out_instr, out_pc_plus4, fetch_fault
    );

endinterface

// File: rtl/fetch_ctrl_fifo.sv
// Synchronous FIFO with flush and occupancy count; flush overrides push/pop.
module fetch_ctrl_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int unsigned PtrW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PtrW-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
    logic [PtrW:0]    count_q, count_d;
    logic             full, empty, do_push, do_pop;

    always_comb begin
        empty   = (count_q == '0);
        full    = (count_q == (PtrW + 1)'(DEPTH));
        do_pop  = pop_i && !empty;
        do_push = push_i && (!full || do_pop);
        mem_d   = mem_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (flush_i) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (do_push) begin
                mem_d[wptr_q] = wdata_i;
                wptr_d        = wptr_q + PtrW'(1);
            end
            if (do_pop) begin
                rptr_d = rptr_q + PtrW'(1);
            end
            count_d = count_q + (PtrW + 1)'(do_push) - (PtrW + 1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: entries are only visible through count_q.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign rdata_o = mem_q[rptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: owns the fetch PC, issues credit-limited in-order memory requests and
// queues responses for decode. Optional misaligned-redirect fault: FETCH_CTRL_ALIGN_CHK_EN.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter int unsigned           DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(FETCH_RESET_PC),
    parameter int unsigned           FQ_DEPTH   = 4
) (
    input logic          clk,
    input logic          rst,
    fetch_ctrl_if.master bus
);
    localparam int unsigned CntW = $clog2(FQ_DEPTH) + 1;
    localparam int unsigned QW   = ADDR_WIDTH + DATA_WIDTH;

    fetch_state_e          state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [CntW-1:0]       inflight_q, inflight_d;
    logic [CntW-1:0]       drop_cnt_q, drop_cnt_d;
    logic [CntW-1:0]       q_count, pcf_count;
    logic [CntW:0]         occupancy;
    logic [ADDR_WIDTH-1:0] pcf_head, redir_pc;
    logic [QW-1:0]         q_head;
    logic                  redirect, redir_misaligned;
    logic                  req, grant, resp_drop, resp_keep, out_fire;

`ifdef FETCH_CTRL_ALIGN_CHK_EN
    assign redir_misaligned = (bus.redirect_addr[1:0] != 2'b00);
    assign redir_pc         = bus.redirect_addr;
    assign bus.fetch_fault  = (state_q == StFault);
`else
    logic unused_redir_lsb;
    assign unused_redir_lsb = ^bus.redirect_addr[1:0];
    assign redir_misaligned = 1'b0;
    assign redir_pc         = {bus.redirect_addr[ADDR_WIDTH-1:2], 2'b00};
    assign bus.fetch_fault  = 1'b0;
`endif

    assign redirect = bus.redirect_taken;

    always_comb begin
        // Dropped responses still hold a slot until they return.
        occupancy  = {1'b0, inflight_q} + {1'b0, q_count};
        req        = (state_q == StRun) && (occupancy < (CntW + 1)'(FQ_DEPTH));
        grant      = req && bus.mem_gnt;
        resp_drop  = bus.mem_rvalid && (drop_cnt_q != '0);
        resp_keep  = bus.mem_rvalid && (drop_cnt_q == '0) && !redirect;
        out_fire   = bus.out_valid && bus.out_ready;
        inflight_d = inflight_q + CntW'(grant) - CntW'(bus.mem_rvalid);

        drop_cnt_d = drop_cnt_q - CntW'(resp_drop);
        pc_d       = pc_q;
        if (grant) begin
            pc_d = pc_q + ADDR_WIDTH'(PC_INCR);
        end
        if (redirect) begin
            drop_cnt_d = inflight_d;
            pc_d       = redir_pc;
        end

        state_d = state_q;
        case (state_q)
            StBoot:  state_d = StRun;
            StRun:   if (redirect && redir_misaligned) state_d = StFault;
            StFault: if (redirect && !redir_misaligned) state_d = StRun;
            default: state_d = StBoot;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StBoot;
            pc_q       <= RESET_PC;
            inflight_q <= '0;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            inflight_q <= inflight_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    fetch_ctrl_fifo #(
        .WIDTH (ADDR_WIDTH),
        .DEPTH (FQ_DEPTH)
    ) u_pc_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush_i (redirect),
        .push_i  (grant && !redirect),
        .wdata_i (pc_q),
        .pop_i   (resp_keep),
        .rdata_o (pcf_head),
        .count_o (pcf_count)
    );

    fetch_ctrl_fifo #(
        .WIDTH (QW),
        .DEPTH (FQ_DEPTH)
    ) u_instr_q (
        .clk     (clk),
        .rst     (rst),
        .flush_i (redirect),
        .push_i  (resp_keep),
        .wdata_i ({pcf_head, bus.mem_rdata}),
        .pop_i   (out_fire),
        .rdata_o (q_head),
        .count_o (q_count)
    );

    assign bus.mem_req      = req;
    assign bus.mem_addr     = pc_q;
    assign bus.out_valid    = (q_count != '0);
    assign bus.out_pc       = q_head[QW-1:DATA_WIDTH];
    assign bus.out_instr    = q_head[DATA_WIDTH-1:0];
    assign bus.out_pc_plus4 = bus.out_pc + ADDR_WIDTH'(PC_INCR);

    a_rvalid_outstanding: assert property (@(posedge clk) disable iff (rst)
        bus.mem_rvalid |-> (inflight_q != '0));
    a_keep_has_pc: assert property (@(posedge clk) disable iff (rst)
        resp_keep |-> (pcf_count != '0));
    a_keep_has_room: assert property (@(posedge clk) disable iff (rst)
        resp_keep |-> (q_count < CntW'(FQ_DEPTH)));

endmodule
